// File: rtl/oam_dma_pkg.sv
// Shared constants, state encoding and address helpers for the OAM DMA engine.
// Imported by oam_dma_controller and oam_dma_bus_arbiter.
package oam_dma_pkg;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN      = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [15:0] ECHO_OFFSET  = 16'h2000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_t;

    // One DMA-side bus request; rd and wr are never both set.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } dma_req_t;

    // Pages E0..FF are the echo mirror of C0..DF, so FE/FF fold to DE/DF.
    function automatic logic [15:0] dma_src_addr(input logic [7:0] page,
                                                 input logic [7:0] idx);
        logic [15:0] addr;
        addr = {page, idx};
        if (page >= 8'hE0) begin
            addr = addr - ECHO_OFFSET;
        end
        return addr;
    endfunction

    function automatic logic cpu_exempt(input logic [15:0] addr,
                                        input logic        wr);
        logic in_hram;
        in_hram = (addr >= HRAM_LO) && (addr <= HRAM_HI);
        return in_hram || (wr && (addr == DMA_REG_ADDR));
    endfunction

endpackage

// File: rtl/oam_dma_bus_arbiter.sv
// Combinational mux of CPU and DMA traffic onto the single MMU bus.
// Define OAM_DMA_BUS_LOCK_EN to block non-exempt CPU accesses for the whole copy.
module oam_dma_bus_arbiter
    import oam_dma_pkg::*;
(
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Di_cpu,
    input  logic        wr_cpu,
    input  logic        rd_cpu,
    output logic [7:0]  Do_cpu,
    input  logic        dma_active,
    input  dma_req_t    dma_req,
    output logic [15:0] A_mmu,
    output logic [7:0]  Do_mmu,
    input  logic [7:0]  Di_mmu,
    output logic        wr_mmu,
    output logic        rd_mmu
);

`ifdef OAM_DMA_BUS_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    logic dma_owns;
    logic cpu_locked;

    assign dma_owns   = dma_req.rd || dma_req.wr;
    assign cpu_locked = LOCK_EN && dma_active && !cpu_exempt(A_cpu, wr_cpu);

    // A DMA phase always wins the strobes; exempt CPU accesses only escape the lock.
    always_comb begin
        A_mmu  = A_cpu;
        Do_mmu = Di_cpu;
        wr_mmu = wr_cpu;
        rd_mmu = rd_cpu;
        Do_cpu = Di_mmu;
        if (dma_owns) begin
            A_mmu  = dma_req.addr;
            Do_mmu = dma_req.data;
            wr_mmu = dma_req.wr;
            rd_mmu = dma_req.rd;
            Do_cpu = 8'hFF;
        end else if (cpu_locked) begin
            wr_mmu = 1'b0;
            rd_mmu = 1'b0;
            Do_cpu = 8'hFF;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA sequencer: owns FF46 and copies 160 bytes into FE00-FE9F.
// Bus blocking policy lives in oam_dma_bus_arbiter (macro OAM_DMA_BUS_LOCK_EN).
module oam_dma_controller
    import oam_dma_pkg::*;
#(
    parameter int BYTE_PERIOD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Di_cpu,
    output logic [7:0]  Do_cpu,
    input  logic        wr_cpu,
    input  logic        rd_cpu,
    output logic [15:0] A_mmu,
    output logic [7:0]  Do_mmu,
    input  logic [7:0]  Di_mmu,
    output logic        wr_mmu,
    output logic        rd_mmu,
    output logic [7:0]  DMA,
    output logic        dma_active
);

    localparam int              PH_W     = $clog2(BYTE_PERIOD);
    localparam logic [PH_W-1:0] PH_ZERO  = '0;
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0] PH_TWO   = PH_W'(2);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BYTE_PERIOD - 1);
    localparam logic [7:0]      IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_t      state, state_next;
    logic [7:0]      idx, idx_next;
    logic [PH_W-1:0] ph, ph_next;
    logic [7:0]      dma_q, dma_next;
    logic [7:0]      data_q, data_next;
    logic            trigger;
    dma_req_t        dma_req;

    assign trigger    = wr_cpu && (A_cpu == DMA_REG_ADDR);
    assign DMA        = dma_q;
    assign dma_active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            ph     <= PH_ZERO;
            dma_q  <= 8'h00;
            data_q <= 8'h00;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            ph     <= ph_next;
            dma_q  <= dma_next;
            data_q <= data_next;
        end
    end

    // A trigger overrides whatever the sequencer was doing, including mid-copy.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        ph_next    = ph;
        dma_next   = dma_q;
        data_next  = data_q;
        case (state)
            IDLE: begin
                idx_next = '0;
                ph_next  = PH_ZERO;
            end
            START: begin
                if (ph == PH_LAST) begin
                    state_next = XFER;
                    idx_next   = '0;
                    ph_next    = PH_ZERO;
                end else begin
                    ph_next = ph + PH_ONE;
                end
            end
            XFER: begin
                if (ph == PH_ONE) begin
                    data_next = Di_mmu;
                end
                if (ph == PH_LAST) begin
                    ph_next = PH_ZERO;
                    if (idx == IDX_LAST) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 8'd1;
                    end
                end else begin
                    ph_next = ph + PH_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                ph_next    = PH_ZERO;
            end
        endcase
        if (trigger) begin
            dma_next   = Di_cpu;
            state_next = START;
            idx_next   = '0;
            ph_next    = PH_ZERO;
        end
    end

    // Source is held for two phases so the one-cycle read latency settles before capture.
    always_comb begin
        dma_req      = '0;
        dma_req.data = data_q;
        if (state == XFER) begin
            if ((ph == PH_ZERO) || (ph == PH_ONE)) begin
                dma_req.rd   = 1'b1;
                dma_req.addr = dma_src_addr(dma_q, idx);
            end else if (ph == PH_TWO) begin
                dma_req.wr   = 1'b1;
                dma_req.addr = OAM_BASE + {8'h00, idx};
            end
        end
    end

    oam_dma_bus_arbiter u_arbiter (
        .A_cpu      (A_cpu),
        .Di_cpu     (Di_cpu),
        .wr_cpu     (wr_cpu),
        .rd_cpu     (rd_cpu),
        .Do_cpu     (Do_cpu),
        .dma_active (dma_active),
        .dma_req    (dma_req),
        .A_mmu      (A_mmu),
        .Do_mmu     (Do_mmu),
        .Di_mmu     (Di_mmu),
        .wr_mmu     (wr_mmu),
        .rd_mmu     (rd_mmu)
    );

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: OAM writes are scored against a queue
// of expected (address, data) pairs filled whenever a copy is triggered.
module tb_oam_dma_controller;

`ifdef OAM_DMA_BUS_LOCK_EN
    localparam logic LOCK = 1'b1;
`else
    localparam logic LOCK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] a_cpu;
    logic [7:0]  di_cpu;
    logic [7:0]  do_cpu;
    logic        wr_cpu;
    logic        rd_cpu;
    logic [15:0] a_mmu;
    logic [7:0]  do_mmu;
    logic [7:0]  di_mmu;
    logic        wr_mmu;
    logic        rd_mmu;
    logic [7:0]  dma_reg;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_q [$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cycle      = 0;
    int trig_cycle = 0;
    int oam_wr_cnt = 0;

    oam_dma_controller #(.BYTE_PERIOD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .A_cpu      (a_cpu),
        .Di_cpu     (di_cpu),
        .Do_cpu     (do_cpu),
        .wr_cpu     (wr_cpu),
        .rd_cpu     (rd_cpu),
        .A_mmu      (a_mmu),
        .Do_mmu     (do_mmu),
        .Di_mmu     (di_mmu),
        .wr_mmu     (wr_mmu),
        .rd_mmu     (rd_mmu),
        .DMA        (dma_reg),
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory with combinational read so a read lands in the same cycle it is issued.
    assign di_mmu = mem[a_mmu];
    always @(posedge clk) begin
        if (wr_mmu) mem[a_mmu] = do_mmu;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a[15:8] == 8'hC0) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h33;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input logic wr, input logic rd);
        a_cpu  = a;
        di_cpu = d;
        wr_cpu = wr;
        rd_cpu = rd;
    endtask

    task automatic push_copy(input logic [7:0] page);
        logic [7:0] sp;
        sp = (page >= 8'hE0) ? page - 8'h20 : page;
        for (int i = 0; i < 160; i++)
            exp_q.push_back({16'hFE00 + 16'(i), pat({sp, 8'(i)})});
    endtask

    task automatic trigger(input logic [7:0] page);
        applyStimulus(16'hFF46, page, 1'b1, 1'b0);
        push_copy(page);
        @(posedge clk);
        #1;
        trig_cycle = cycle;
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    // Cycle k=1 is the first cycle after the trigger edge.
    task automatic goto_k(input int k);
        for (int i = 0; i < 5000 && cycle < trig_cycle + k - 1; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_until_idle(output int active, output int first_rd,
                                  output logic [15:0] lo, output logic [15:0] hi);
        active   = 0;
        first_rd = -1;
        lo       = 16'hFFFF;
        hi       = 16'h0000;
        for (int i = 0; i < 2000; i++) begin
            if (!dma_active) break;
            if (rd_mmu) begin
                if (first_rd < 0) first_rd = i;
                if (a_mmu < lo) lo = a_mmu;
                if (a_mmu > hi) hi = a_mmu;
            end
            active++;
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (wr_mmu && a_mmu >= 16'hFE00 && a_mmu <= 16'hFE9F) begin
            logic [23:0] e;
            oam_wr_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("[TB] FAIL oam_unexpected_wr observed=%h/%h expected=none", a_mmu, do_mmu);
                end
            end else begin
                e = exp_q.pop_front();
                checkOutput("oam_wr_addr", a_mmu, e[23:8]);
                checkOutput("oam_wr_data", {8'h00, do_mmu}, {8'h00, e[7:0]});
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int act, frd, lows, w0;
        logic [15:0] lo, hi;

        reset = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(16'h1234, 8'h00, 1'b0, 1'b1);
        #1;
        checkOutput("reset_active", 16'(dma_active), 16'd0);
        checkOutput("reset_dma", 16'(dma_reg), 16'h0000);
        checkOutput("reset_a_mmu", a_mmu, 16'h1234);
        checkOutput("reset_rd_mmu", 16'(rd_mmu), 16'd1);
        checkOutput("reset_wr_mmu", 16'(wr_mmu), 16'd0);
        checkOutput("reset_do_cpu", 16'(do_cpu), 16'(pat(16'h1234)));
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_active", 16'(dma_active), 16'd0);

        $display("[TB] basic copy from C0");
        trigger(8'hC0);
        checkOutput("basic_active_t1", 16'(dma_active), 16'd1);
        run_until_idle(act, frd, lo, hi);
        checkOutput("basic_active_len", 16'(act), 16'd644);
        checkOutput("basic_first_rd", 16'(frd), 16'd4);
        checkOutput("basic_src_lo", lo, 16'hC000);
        checkOutput("basic_src_hi", hi, 16'hC09F);
        checkOutput("basic_dma_reg", 16'(dma_reg), 16'h00C0);
        checkOutput("basic_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("[TB] echo mirror from FE");
        trigger(8'hFE);
        run_until_idle(act, frd, lo, hi);
        checkOutput("echo_active_len", 16'(act), 16'd644);
        checkOutput("echo_src_lo", lo, 16'hDE00);
        checkOutput("echo_src_hi", hi, 16'hDE9F);
        checkOutput("echo_dma_reg", 16'(dma_reg), 16'h00FE);
        checkOutput("echo_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("[TB] restart C0 -> D0 at idx 50");
        trigger(8'hC0);
        lows = 0;
        for (int k = 1; k < 205; k++) begin
            if (!dma_active) lows++;
            @(posedge clk);
            #1;
        end
        applyStimulus(16'hFF46, 8'hD0, 1'b1, 1'b0);
        #1;
        checkOutput("restart_rd_mmu", 16'(rd_mmu), 16'd1);
        checkOutput("restart_wr_dropped", 16'(wr_mmu), 16'd0);
        checkOutput("restart_a_mmu", a_mmu, 16'hC032);
        exp_q.delete();
        push_copy(8'hD0);
        @(posedge clk);
        #1;
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        run_until_idle(act, frd, lo, hi);
        checkOutput("restart_no_low", 16'(lows), 16'd0);
        checkOutput("restart_active_len", 16'(act), 16'd644);
        checkOutput("restart_dma_reg", 16'(dma_reg), 16'h00D0);
        checkOutput("restart_queue_empty", 16'(exp_q.size()), 16'd0);
        for (int i = 0; i < 160; i++)
            checkOutput("restart_oam", 16'(mem[16'hFE00 + 16'(i)]), 16'(pat(16'hD000 + 16'(i))));

        $display("[TB] cpu access during copy (lock=%0d)", LOCK);
        trigger(8'hC0);
        goto_k(2);
        applyStimulus(16'hC123, 8'h00, 1'b0, 1'b1);
        #1;
        checkOutput("start_read", 16'(do_cpu), LOCK ? 16'h00FF : 16'(pat(16'hC123)));
        checkOutput("start_rd_mmu", 16'(rd_mmu), LOCK ? 16'd0 : 16'd1);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        goto_k(48);
        applyStimulus(16'hC123, 8'h00, 1'b0, 1'b1);
        #1;
        checkOutput("free_read", 16'(do_cpu), LOCK ? 16'h00FF : 16'(pat(16'hC123)));
        checkOutput("free_rd_mmu", 16'(rd_mmu), LOCK ? 16'd0 : 16'd1);
        goto_k(49);
        #1;
        checkOutput("owned_read", 16'(do_cpu), 16'h00FF);
        checkOutput("owned_a_mmu", a_mmu, 16'hC00B);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        goto_k(52);
        applyStimulus(16'hD000, 8'hA5, 1'b1, 1'b0);
        goto_k(53);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        goto_k(55);
        applyStimulus(16'hD001, 8'h5C, 1'b1, 1'b0);
        #1;
        checkOutput("owned_wr_addr", a_mmu, 16'hFE0C);
        checkOutput("owned_wr_data", 16'(do_mmu), 16'(pat(16'hC00C)));
        goto_k(56);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        goto_k(60);
        applyStimulus(16'hFF90, 8'h3C, 1'b1, 1'b0);
        goto_k(61);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        goto_k(64);
        applyStimulus(16'hFF90, 8'h00, 1'b0, 1'b1);
        #1;
        checkOutput("hram_read", 16'(do_cpu), 16'h003C);
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
        run_until_idle(act, frd, lo, hi);
        checkOutput("cpu_queue_empty", 16'(exp_q.size()), 16'd0);
        checkOutput("free_write_d000", 16'(mem[16'hD000]), LOCK ? 16'(pat(16'hD000)) : 16'h00A5);
        checkOutput("owned_write_d001", 16'(mem[16'hD001]), 16'(pat(16'hD001)));

        $display("[TB] reset at idx 80");
        trigger(8'hC0);
        goto_k(325);
        reset = 1'b1;
        exp_q.delete();
        w0 = oam_wr_cnt;
        @(posedge clk);
        #1;
        checkOutput("rst_active", 16'(dma_active), 16'd0);
        checkOutput("rst_dma", 16'(dma_reg), 16'h0000);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_no_oam_wr", 16'(oam_wr_cnt), 16'(w0));
        checkOutput("rst_stays_idle", 16'(dma_active), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
